idct_block_streamer: RTL and testbench

- Parametrised streaming adapter around a fixed-latency, fully pipelined, non-stallable block kernel such as the 64-port IDCT.
- Deserialises a valid/ready element stream into one flat block bus and issues each completed block to the kernel.
- Tracks the in-flight block through the kernel latency with a shift register, captures the kernel result into a block buffer, and re-serialises it with backpressure.
- Credit-based issue guarantees that no kernel result is ever dropped.

---
 rtl/idct_block_streamer.sv | 124 ++++++++++++
 tb/tb_idct_block_streamer.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_block_streamer.sv
// idct_block_streamer: connects a valid/ready element stream to a fixed-latency,
// non-stallable block kernel. Incoming elements are gathered into kern_x, and
// each complete block is issued to the kernel. KERNEL_LAT edges later the result
// is captured into a block buffer and replayed as an element stream with
// backpressure. A block is issued only when a buffer slot is reserved for it
// (credits), so a kernel result is never dropped.
module idct_block_streamer #(
  parameter int DATA_W     = 16,
  parameter int BLK_N      = 64,
  parameter int KERNEL_LAT = 29,
  parameter int OUT_DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [BLK_N*DATA_W-1:0]  kern_x,
  input  logic [BLK_N*DATA_W-1:0]  kern_out,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy
);

  localparam int CNT_W = $clog2(BLK_N);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int OCC_W = $clog2(OUT_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLK_N - 1);
  localparam logic [OCC_W-1:0] FULL_CR  = OCC_W'(OUT_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUT_DEPTH - 1);

  logic [CNT_W-1:0]        in_cnt;
  logic                    bubble;
  logic [KERNEL_LAT-1:0]   tracker;
  logic [OCC_W-1:0]        credits;
  logic [OCC_W-1:0]        occ;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        rd_idx;
  logic [BLK_N*DATA_W-1:0] buf_mem [OUT_DEPTH];
  logic [BLK_N*DATA_W-1:0] head_blk;

  logic accept;
  logic issue;
  logic capture;
  logic xfer;
  logic pop;

  // Circular pointer advance over a buffer depth that need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // The last element of a block is held off unless a buffer slot can be reserved;
  // the cycle after an issue is skipped so kern_x is stable when the kernel samples.
  assign in_ready = !rst && !bubble && !((in_cnt == LAST_IDX) && (credits == '0));
  assign accept   = in_valid && in_ready;
  assign issue    = accept && (in_cnt == LAST_IDX);
  assign capture  = tracker[KERNEL_LAT-1];

  assign out_valid = (occ != '0);
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && (rd_idx == LAST_IDX);
  assign out_last  = out_valid && (rd_idx == LAST_IDX);
  assign head_blk  = buf_mem[rd_ptr];
  assign busy      = (in_cnt != '0) || (tracker != '0) || (occ != '0);

  // Output element: head block slot rd_idx, forced to zero while nothing is buffered
  always_comb begin
    out_data = '0;
    if (out_valid) out_data = head_blk[int'(rd_idx)*DATA_W +: DATA_W];
  end

  // Input stage: write each accepted element into its kern_x slot, wrap at block end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt <= '0;
      bubble <= 1'b0;
      kern_x <= '0;
    end else begin
      bubble <= issue;
      if (accept) begin
        kern_x[int'(in_cnt)*DATA_W +: DATA_W] <= in_data;
        in_cnt <= issue ? '0 : in_cnt + 1'b1;
      end
    end
  end

  // Kernel stage: one bit per in-flight block, its arrival marks kern_out as valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tracker <= '0;
    end else begin
      tracker <= (tracker << 1) | KERNEL_LAT'(issue);
    end
  end

  // Buffer control: pointers, occupancy, read index and issue credits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_idx  <= '0;
      occ     <= '0;
      credits <= FULL_CR;
    end else begin
      if (capture) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (xfer) rd_idx <= pop ? '0 : rd_idx + 1'b1;
      if (capture && !pop) occ <= occ + 1'b1;
      else if (pop && !capture) occ <= occ - 1'b1;
      if (issue && !pop) credits <= credits - 1'b1;
      else if (pop && !issue) credits <= credits + 1'b1;
    end
  end

  // Capture stage: store the finished kernel result at the buffer tail
  always_ff @(posedge clk) begin
    if (capture) buf_mem[wr_ptr] <= kern_out;
  end

endmodule

// File: tb/tb_idct_block_streamer.sv
// Bench for idct_block_streamer: a real-valued 8x8 IDCT kernel model behind the
// default instance and an identity kernel behind a small (BLK_N=4, LAT=1) one.
// Stimulus pushes expected elements into queues; monitors pop and compare.
module tb_idct_block_streamer;
  localparam int AW = 16, AN = 64, AL = 29, AD = 2;
  localparam int BW = 8,  BN = 4,  BL = 1,  BD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err = 0;

  typedef struct { int d; bit l; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  exp_t a_e, b_e;

  // Instance A
  logic signed [AW-1:0] a_in_data;
  logic                 a_in_valid, a_in_ready;
  logic [AN*AW-1:0]     a_kern_x, a_kern_out;
  logic signed [AW-1:0] a_out_data;
  logic                 a_out_valid, a_out_ready, a_out_last, a_busy;

  // Instance B
  logic signed [BW-1:0] b_in_data;
  logic                 b_in_valid, b_in_ready;
  logic [BN*BW-1:0]     b_kern_x, b_kern_out;
  logic signed [BW-1:0] b_out_data;
  logic                 b_out_valid, b_out_ready, b_out_last, b_busy;

  idct_block_streamer #(.DATA_W(AW), .BLK_N(AN), .KERNEL_LAT(AL), .OUT_DEPTH(AD)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .kern_x(a_kern_x), .kern_out(a_kern_out), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_last(a_out_last), .busy(a_busy));

  idct_block_streamer #(.DATA_W(BW), .BLK_N(BN), .KERNEL_LAT(BL), .OUT_DEPTH(BD)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .kern_x(b_kern_x), .kern_out(b_kern_out), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_last(b_out_last), .busy(b_busy));

  task automatic check(input string nm, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  function automatic int rnd_sat(input real x);
    int r;
    if (x >= 0.0) r = $rtoi(x + 0.5);
    else r = -$rtoi(-x + 0.5);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // Reference 8x8 IDCT: f[v*8+u] coefficients -> o[y*8+x] samples
  task automatic idct_ref(input int f[64], output int o[64]);
    real ct [8][8];
    real tmp [8][8];
    real s;
    for (int x = 0; x < 8; x++)
      for (int u = 0; u < 8; u++)
        ct[x][u] = ((u == 0) ? 0.70710678118654752 : 1.0) *
                   $cos((2.0 * x + 1.0) * u * 3.14159265358979323846 / 16.0);
    for (int v = 0; v < 8; v++)
      for (int x = 0; x < 8; x++) begin
        s = 0.0;
        for (int u = 0; u < 8; u++) s = s + ct[x][u] * f[v*8+u];
        tmp[v][x] = s;
      end
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        s = 0.0;
        for (int v = 0; v < 8; v++) s = s + ct[y][v] * tmp[v][x];
        o[y*8+x] = rnd_sat(0.25 * s);
      end
  endtask

  // Kernel model A: combinational IDCT followed by AL-1 register stages
  logic [AN*AW-1:0] kern_comb;
  logic [AN*AW-1:0] kp [0:AL-2];
  always @(a_kern_x) begin : kmodel
    int f[64];
    int o[64];
    for (int i = 0; i < 64; i++) f[i] = int'($signed(a_kern_x[i*AW +: AW]));
    idct_ref(f, o);
    for (int i = 0; i < 64; i++) kern_comb[i*AW +: AW] = AW'(o[i]);
  end
  always @(posedge clk) begin
    kp[0] <= kern_comb;
    for (int i = 1; i < AL - 1; i++) kp[i] <= kp[i-1];
  end
  assign a_kern_out = kp[AL-2];

  // Kernel model B: identity
  assign b_kern_out = b_kern_x;

  // Output ready pattern for A: 0 = always, 1 = never, 2 = toggle each cycle
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: a_out_ready = 1'b1;
      1: a_out_ready = 1'b0;
      default: a_out_ready = ~a_out_ready;
    endcase
  end

  // Monitor A
  int a_rec [0:255];
  bit a_rec_l [0:255];
  int a_rec_n = 0;
  int a_rise = -1;
  int a_last_x = -1;
  bit a_pv = 0, a_pr = 0, a_pl = 0;
  int a_pd = 0;
  always @(negedge clk) begin
    if (rst) begin
      a_pv = 1'b0;
    end else begin
      check("a_credit_invariant",
            int'(dut_a.credits) + $countones(dut_a.tracker) + int'(dut_a.occ), AD);
      if (a_pv && !a_pr) begin
        check("a_stall_valid", a_out_valid, 1);
        check("a_stall_data", a_out_data, a_pd);
        check("a_stall_last", a_out_last, a_pl);
      end
      if (a_out_valid && !a_pv && a_rise < 0) a_rise = cyc;
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL a_unexpected_output: actual %0d required no output", a_out_data);
        end else begin
          a_e = qa.pop_front();
          check("a_data", a_out_data, a_e.d);
          check("a_last", a_out_last, a_e.l);
        end
        if (a_rec_n < 256) begin
          a_rec[a_rec_n] = a_out_data;
          a_rec_l[a_rec_n] = a_out_last;
        end
        a_rec_n++;
        if (a_out_last && a_last_x < 0) a_last_x = cyc + 1;
      end
      a_pv = a_out_valid;
      a_pr = a_out_ready;
      a_pd = a_out_data;
      a_pl = a_out_last;
    end
  end

  // Monitor B
  int b_rec [0:7];
  bit b_rec_l [0:7];
  int b_rec_n = 0;
  int b_rise = -1;
  bit b_pv = 0;
  always @(negedge clk) begin
    if (rst) begin
      b_pv = 1'b0;
    end else begin
      check("b_credit_invariant",
            int'(dut_b.credits) + $countones(dut_b.tracker) + int'(dut_b.occ), BD);
      if (b_out_valid && !b_pv && b_rise < 0) b_rise = cyc;
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL b_unexpected_output: actual %0d required no output", b_out_data);
        end else begin
          b_e = qb.pop_front();
          check("b_data", b_out_data, b_e.d);
          check("b_last", b_out_last, b_e.l);
        end
        if (b_rec_n < 8) begin
          b_rec[b_rec_n] = b_out_data;
          b_rec_l[b_rec_n] = b_out_last;
        end
        b_rec_n++;
      end
      b_pv = b_out_valid;
    end
  end

  int a_blk_pos = -1;

  task automatic send_a(input int v, output int acc);
    int w = 0;
    a_in_valid = 1'b1;
    a_in_data = AW'(v);
    @(negedge clk);
    while (!a_in_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) check("a_in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic send_block_a(input int b[64], input bit drop, output int e0);
    int o[64];
    int c = 0;
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      send_a(b[i], c);
      a_blk_pos = i;
    end
    e0 = c;
    idct_ref(b, o);
    for (int i = 0; i < 64; i++) begin
      e.d = o[i];
      e.l = (i == 63);
      qa.push_back(e);
    end
    if (drop) a_in_valid = 1'b0;
  endtask

  task automatic send_b(input int v, input bit last, output int acc);
    int w = 0;
    exp_t e;
    b_in_valid = 1'b1;
    b_in_data = BW'(v);
    @(negedge clk);
    while (!b_in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check("b_in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    acc = cyc;
    e.d = v;
    e.l = last;
    qb.push_back(e);
  endtask

  task automatic wait_rec_a(input int n, input int budget);
    int w = 0;
    while (a_rec_n < n && w < budget) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("a_output_count", a_rec_n, n);
  endtask

  task automatic gen_blk(input int k, output int b[64]);
    for (int i = 0; i < 64; i++) b[i] = ((i * 5 + k * 11 + 3) % 23) - 11;
  endtask

  int tv0 [64];
  int blk [64];
  int blk2 [64];
  int blk3 [64];
  int e0, e1, e2, ex;
  bit saw_v;
  int bvals [4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    for (int i = 0; i < 64; i++) tv0[i] = 0;
    tv0[0] = -166; tv0[1] = -7; tv0[2] = -4; tv0[3] = -4; tv0[8] = -2; tv0[16] = -2;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_last", a_out_last, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_busy", a_busy, 0);
    check("rst_kern_x_zero", (a_kern_x == '0), 1);
    check("rst_b_in_ready", b_in_ready, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", a_in_ready, 1);
    @(posedge clk);
    #1;

    // Single block
    a_rec_n = 0; a_rise = -1;
    send_block_a(tv0, 1'b1, e0);
    check("single_bubble_in_ready", a_in_ready, 0);
    check("single_busy_in_flight", a_busy, 1);
    @(posedge clk);
    #1;
    check("single_in_ready_after_bubble", a_in_ready, 1);
    wait_rec_a(64, 300);
    check("single_busy_fall", a_busy, 0);
    check("single_valid_fall", a_out_valid, 0);
    check("single_latency", a_rise - e0, AL);
    check("single_elem0", a_rec[0], -24);
    check("single_elem1", a_rec[1], -23);
    check("single_elem7", a_rec[7], -20);
    check("single_elem63", a_rec[63], -20);
    check("single_last63", a_rec_l[63], 1);
    check("single_last62", a_rec_l[62], 0);

    // Back-to-back input
    a_rec_n = 0;
    gen_blk(1, blk);
    gen_blk(2, blk2);
    send_block_a(blk, 1'b0, e1);
    send_block_a(blk2, 1'b1, e2);
    check("b2b_issue_spacing", e2 - e1, 65);
    wait_rec_a(128, 500);

    // Backpressure and credits
    rdy_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    a_rec_n = 0; a_last_x = -1; a_blk_pos = -1;
    gen_blk(3, blk);
    gen_blk(4, blk2);
    gen_blk(5, blk3);
    fork
      begin
        send_block_a(blk, 1'b0, ex);
        send_block_a(blk2, 1'b0, ex);
        send_block_a(blk3, 1'b1, e0);
      end
      begin
        repeat (260) @(posedge clk);
        #1;
        check("bp_in_ready_low", a_in_ready, 0);
        check("bp_held_before_63", a_blk_pos, 62);
        check("bp_nothing_out", a_rec_n, 0);
        rdy_mode = 0;
      end
    join
    check("bp_release_after_pop", e0 - a_last_x, 1);
    wait_rec_a(192, 1000);

    // Output stall
    rdy_mode = 2;
    a_rec_n = 0;
    gen_blk(6, blk);
    gen_blk(7, blk2);
    send_block_a(blk, 1'b0, ex);
    send_block_a(blk2, 1'b1, ex);
    wait_rec_a(128, 2000);
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-flight
    a_rec_n = 0;
    send_block_a(tv0, 1'b1, e0);
    while (cyc < e0 + 10) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("midrst_out_valid", a_out_valid, 0);
    check("midrst_in_ready", a_in_ready, 0);
    check("midrst_busy", a_busy, 0);
    qa.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw_v = 1'b0;
    while (cyc < e0 + 35) begin
      @(posedge clk);
      #1;
      saw_v = saw_v | a_out_valid;
    end
    check("midrst_no_stale_output", saw_v, 0);
    check("midrst_no_records", a_rec_n, 0);
    a_rise = -1;
    send_block_a(tv0, 1'b1, e0);
    wait_rec_a(64, 300);
    check("fresh_latency", a_rise - e0, AL);
    check("fresh_elem0", a_rec[0], -24);
    check("fresh_elem63", a_rec[63], -20);
    check("fresh_last63", a_rec_l[63], 1);

    // Parameter sweep instance
    bvals[0] = 1; bvals[1] = -2; bvals[2] = 3; bvals[3] = -4;
    b_rec_n = 0; b_rise = -1;
    for (int i = 0; i < 4; i++) send_b(bvals[i], (i == 3), e0);
    b_in_valid = 1'b0;
    for (int w = 0; w < 50 && b_rec_n < 4; w++) begin
      @(posedge clk);
      #1;
    end
    check("b_output_count", b_rec_n, 4);
    check("b_latency", b_rise - e0, BL);
    check("b_elem0", b_rec[0], 1);
    check("b_elem1", b_rec[1], -2);
    check("b_elem2", b_rec[2], 3);
    check("b_elem3", b_rec[3], -4);
    check("b_last3", b_rec_l[3], 1);
    check("b_last2", b_rec_l[2], 0);
    check("b_busy_idle", b_busy, 0);

    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
